press_classifier: RTL and testbench
===================================

# press_classifier

- Downstream stage of the glitch filter: consumes its filtered, stable level `sig_out` on the `sig_in` port.
- Measures each high interval and classifies it as runt (ignored), short press, long press or, optionally, double press.
- Emits one-cycle event pulses and keeps a wrapping event counter for the control logic.

## Interface
- `CNT_W`, 16: width of the hold and gap counters.
- `LONG_TICKS`, 1000: high samples needed to report a long press.
- `MIN_TICKS`, 2: minimum high samples for a valid press. Shorter presses are runts.
- `GAP_TICKS`, 300: double-press window, in low samples after a short release.
- `EVT_CNT_W`, 8: event counter width.
- Legal ranges:
  - 1 ≤ `MIN_TICKS` < `LONG_TICKS` < 2^`CNT_W`
  - 1 ≤ `GAP_TICKS` < 2^`CNT_W`

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `sig_in` in 1: filtered level from the filter stage.
- `clear_count` in 1: synchronous clear of `evt_count`.
- `pressed` out 1: registered copy of the FSM "press active" condition. It is 1 in PRESS and HELD.
- `short_evt` out 1: one-cycle pulse.
- `long_evt` out 1: one-cycle pulse.
- `double_evt` out 1: one-cycle pulse. Constant 0 unless `DOUBLE_CLICK_EN` is defined.
- `hold_cnt` out `CNT_W`: length of the current or last press, in samples. Saturates at all-ones.
- `evt_count` out `EVT_CNT_W`: number of events, wraps modulo 2^`EVT_CNT_W`.

## Operation
- States: IDLE, PRESS, HELD, GAP. GAP exists only with `DOUBLE_CLICK_EN`.
- All outputs are registered. Every output resets to 0 and the state resets to IDLE.
- IDLE:
  - `sig_in`=1 → PRESS, with `hold_cnt`←1.
  - `hold_cnt` otherwise holds its last value.
- PRESS, `sig_in`=1:
  - `hold_cnt`++.
  - If `hold_cnt` = `LONG_TICKS`-1: `long_evt`←1, → HELD.
- PRESS, `sig_in`=0:
  - If `hold_cnt` < `MIN_TICKS`: → IDLE with no event (runt).
  - Otherwise, without the macro: `short_evt`←1, → IDLE.
  - Otherwise, with the macro: → GAP, gap counter←1.
- HELD:
  - `hold_cnt` saturating ++ while `sig_in`=1.
  - `sig_in`=0 → IDLE, no event.
- GAP:
  - `sig_in`=1: `double_evt`←1, → HELD, `hold_cnt`←1. HELD prevents a long event for that press.
  - `sig_in`=0 and gap counter = `GAP_TICKS`: `short_evt`←1, → IDLE.
  - `sig_in`=0 otherwise: gap counter++.
- `evt_count`:
  - +1 on any event pulse. At most one event fires per cycle.
  - `clear_count` forces 0 and wins over a same-cycle increment.
- Reset mid-press: everything returns to 0/IDLE immediately. If `sig_in` is still 1 after release, the press is treated as a new one from the first sampled edge.

## Timing
- A press of N consecutive high samples, starting with no macro defined:
  - N < `MIN_TICKS`: no event.
  - `MIN_TICKS` ≤ N < `LONG_TICKS`: `short_evt` is high in the cycle after the edge that samples the first 0.
  - N ≥ `LONG_TICKS`: `long_evt` is high in the cycle after the edge that samples the `LONG_TICKS`-th 1.
- Event pulses last exactly one cycle. `evt_count` updates on the same edge that raises the pulse.
- With the macro, `short_evt` is delayed by `GAP_TICKS` cycles after release.
- `pressed` rises one edge after the first sampled 1 and falls one edge after the release sample.
- No combinational path from any input to any output.

## Configuration
- Macro: `PRESS_CLASSIFIER_DOUBLE_CLICK_EN`.
- Defined: GAP state and gap counter are built, and `double_evt` is live.
- Undefined: GAP logic is absent, `double_evt` is tied 0, and `short_evt` fires immediately on release.

## Structure
- Package `press_pkg` holds:
  - the state enum typedef (IDLE, PRESS, HELD, GAP)
  - the 2-bit event-code constants `EVT_NONE`, `EVT_SHORT`, `EVT_LONG`, `EVT_DOUBLE`, used internally to drive the pulses and the counter
- Sub-module `sat_counter` (parameter `W`; inputs `load`, `inc`; output `q`, saturating). It is instantiated for the hold counter and, with the macro, the gap counter.

## Test plan
Bench parameters: `LONG_TICKS`=8, `MIN_TICKS`=2, `GAP_TICKS`=4.
- Runt: `sig_in` high for 1 sample → no event pulse, `evt_count` stays 0, `hold_cnt`=1.
- Short, no macro: high for 5 samples → `short_evt` for 1 cycle after the first low sample, `hold_cnt`=5, `evt_count`=1.
- Long: high for 20 samples → `long_evt` 1 cycle after the 8th sample, with no event on release. `hold_cnt`=20, `evt_count`=1.
- Double, macro defined:
  - high 3, low 2, high 3 → `double_evt` one cycle after the second rise; no `short_evt`, no `long_evt`; `evt_count`=1.
  - high 3, low 6 → `short_evt` 4 cycles after release.
- Reset and clear:
  - Assert `reset` at sample 5 of a press → outputs 0 at once, with no event.
  - After release with `sig_in` still high → new press; `long_evt` after 8 samples.
  - `clear_count` on the same edge as an event → `evt_count`=0.
- Wrap: 256 short presses with `EVT_CNT_W`=8 → `evt_count` returns to 0.

Source files
------------

// File: rtl/press_pkg.sv
// Purpose: shared types and constants for the press classifier.
// Latency: n/a (declarations only).
// Backpressure: n/a; event codes select which one-cycle pulse fires.
package press_pkg;

  // Classifier FSM states; GAP is only reachable with double-click support.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    HELD  = 2'd2,
    GAP   = 2'd3
  } state_e;

  // Internal event codes; at most one event is produced per cycle.
  localparam logic [1:0] EVT_NONE   = 2'd0;
  localparam logic [1:0] EVT_SHORT  = 2'd1;
  localparam logic [1:0] EVT_LONG   = 2'd2;
  localparam logic [1:0] EVT_DOUBLE = 2'd3;

endpackage

// File: rtl/press_classifier_sat_counter.sv
// Purpose: W-bit saturating up-counter with load-to-one.
// Latency: q updates on the clock edge after load/inc.
// Backpressure: none; inc at all-ones is ignored (saturates).
// Ports: clock, reset (async, active-high), load (q <- 1, wins over inc),
//        inc (q <- q+1 unless all-ones), q (count).
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // Loading 1 rather than 0: the load happens on the cycle that already
  // counts as the first sample of the interval being measured.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = W'(1);
    end else if (inc && (q_q != '1)) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/press_classifier.sv
// Purpose: classify high intervals of a filtered level as runt/short/long/double press.
// Latency: all outputs registered; events appear the cycle after the deciding sample.
// Backpressure: none; pulses are fire-and-forget, evt_count wraps.
// Ports: clock, reset (async, active-high), sig_in (filtered level),
//        clear_count (sync clear of evt_count), pressed, short_evt, long_evt,
//        double_evt, hold_cnt [CNT_W], evt_count [EVT_CNT_W].
// Option: define PRESS_CLASSIFIER_DOUBLE_CLICK_EN to build the GAP state,
//         gap counter and live double_evt (short_evt is then delayed).
module press_classifier
  import press_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int LONG_TICKS = 1000,
  parameter int MIN_TICKS  = 2,
  parameter int GAP_TICKS  = 300,
  parameter int EVT_CNT_W  = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 sig_in,
  input  logic                 clear_count,
  output logic                 pressed,
  output logic                 short_evt,
  output logic                 long_evt,
  output logic                 double_evt,
  output logic [CNT_W-1:0]     hold_cnt,
  output logic [EVT_CNT_W-1:0] evt_count
);

  if ((MIN_TICKS < 1) || (MIN_TICKS >= LONG_TICKS) ||
      (64'(LONG_TICKS) >= (64'(1) << CNT_W)) ||
      (GAP_TICKS < 1) || (64'(GAP_TICKS) >= (64'(1) << CNT_W))) begin : g_bad_params
    $error("press_classifier: illegal parameter combination");
  end

  localparam logic [CNT_W-1:0] LONG_M1 = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] MIN_V   = CNT_W'(MIN_TICKS);

  state_e                 state_q;
  state_e                 state_d;
  logic [1:0]             evt_d;
  logic                   hold_load;
  logic                   hold_inc;
  logic [CNT_W-1:0]       hold_q;
  logic                   pressed_q;
  logic                   pressed_d;
  logic                   short_q;
  logic                   long_q;
  logic [EVT_CNT_W-1:0]   evt_count_q;
  logic [EVT_CNT_W-1:0]   evt_count_d;

`ifdef PRESS_CLASSIFIER_DOUBLE_CLICK_EN
  logic                   gap_load;
  logic                   gap_inc;
  logic [CNT_W-1:0]       gap_q;
  logic                   double_q;
  localparam logic [CNT_W-1:0] GAP_V = CNT_W'(GAP_TICKS);

  sat_counter #(.W(CNT_W)) u_gap_cnt (
    .clock (clock),
    .reset (reset),
    .load  (gap_load),
    .inc   (gap_inc),
    .q     (gap_q)
  );
`endif

  sat_counter #(.W(CNT_W)) u_hold_cnt (
    .clock (clock),
    .reset (reset),
    .load  (hold_load),
    .inc   (hold_inc),
    .q     (hold_q)
  );

  always_comb begin
    state_d   = state_q;
    evt_d     = EVT_NONE;
    hold_load = 1'b0;
    hold_inc  = 1'b0;
`ifdef PRESS_CLASSIFIER_DOUBLE_CLICK_EN
    gap_load  = 1'b0;
    gap_inc   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (sig_in) begin
          state_d   = PRESS;
          hold_load = 1'b1;
        end
      end
      PRESS: begin
        if (sig_in) begin
          hold_inc = 1'b1;
          // hold_q is about to become LONG_TICKS: this sample is the long one.
          if (hold_q == LONG_M1) begin
            evt_d   = EVT_LONG;
            state_d = HELD;
          end
        end else if (hold_q < MIN_V) begin
          state_d = IDLE;  // runt: dropped silently
        end else begin
`ifdef PRESS_CLASSIFIER_DOUBLE_CLICK_EN
          state_d  = GAP;
          gap_load = 1'b1;
`else
          evt_d   = EVT_SHORT;
          state_d = IDLE;
`endif
        end
      end
      HELD: begin
        if (sig_in) begin
          hold_inc = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
`ifdef PRESS_CLASSIFIER_DOUBLE_CLICK_EN
      GAP: begin
        if (sig_in) begin
          // Second press goes straight to HELD so it can never also be long.
          evt_d     = EVT_DOUBLE;
          state_d   = HELD;
          hold_load = 1'b1;
        end else if (gap_q == GAP_V) begin
          evt_d   = EVT_SHORT;
          state_d = IDLE;
        end else begin
          gap_inc = 1'b1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    pressed_d   = (state_d == PRESS) || (state_d == HELD);
    evt_count_d = evt_count_q;
    if (clear_count) begin
      evt_count_d = '0;
    end else if (evt_d != EVT_NONE) begin
      evt_count_d = evt_count_q + EVT_CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pressed_q   <= 1'b0;
      short_q     <= 1'b0;
      long_q      <= 1'b0;
      evt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      pressed_q   <= pressed_d;
      short_q     <= (evt_d == EVT_SHORT);
      long_q      <= (evt_d == EVT_LONG);
      evt_count_q <= evt_count_d;
    end
  end

`ifdef PRESS_CLASSIFIER_DOUBLE_CLICK_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      double_q <= 1'b0;
    end else begin
      double_q <= (evt_d == EVT_DOUBLE);
    end
  end
  assign double_evt = double_q;
`else
  assign double_evt = 1'b0;
`endif

  assign pressed   = pressed_q;
  assign short_evt = short_q;
  assign long_evt  = long_q;
  assign hold_cnt  = hold_q;
  assign evt_count = evt_count_q;

endmodule

// File: tb/tb_press_classifier.sv
// Purpose: directed self-checking bench for press_classifier with an event scoreboard.
// Latency: expected events carry the cycle on which the pulse must be visible.
// Backpressure: n/a.
module tb_press_classifier;

  localparam int LONG = 8;
  localparam int MINT = 2;
  localparam int GAPT = 4;
`ifdef PRESS_CLASSIFIER_DOUBLE_CLICK_EN
  localparam int SHORT_J = GAPT + 1;  // low sample index that fires short
`else
  localparam int SHORT_J = 1;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sig_in = 1'b0;
  logic        clear_count = 1'b0;
  logic        pressed;
  logic        short_evt;
  logic        long_evt;
  logic        double_evt;
  logic [15:0] hold_cnt;
  logic [7:0]  evt_count;

  typedef struct {
    int kind;    // 1 short, 2 long, 3 double
    int edge_n;  // cycle number at which the pulse is visible
    int cnt;     // evt_count expected alongside the pulse
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   mon_code;
  int   cyc = 0;
  int   exp_cnt = 0;
  int   tests = 0;
  int   fails = 0;

  press_classifier #(
    .CNT_W(16), .LONG_TICKS(LONG), .MIN_TICKS(MINT), .GAP_TICKS(GAPT), .EVT_CNT_W(8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .sig_in      (sig_in),
    .clear_count (clear_count),
    .pressed     (pressed),
    .short_evt   (short_evt),
    .long_evt    (long_evt),
    .double_evt  (double_evt),
    .hold_cnt    (hold_cnt),
    .evt_count   (evt_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Change inputs on the falling edge; the next rising edge samples them.
  task automatic drive(input logic s);
    @(negedge clock);
    sig_in = s;
  endtask

  task automatic push(input int kind, input int edge_n);
    exp_cnt = (exp_cnt + 1) % 256;
    exp_q.push_back('{kind, edge_n, exp_cnt});
  endtask

  // n high samples then nlow low samples, with the expected events queued.
  task automatic press(input int n, input int nlow);
    for (int i = 1; i <= n; i++) begin
      drive(1'b1);
      if (i == LONG) push(2, cyc + 1);
    end
    for (int j = 1; j <= nlow; j++) begin
      drive(1'b0);
      if (j == 1) chk("pressed_high", int'(pressed), 1);
      if (j == 2) chk("pressed_low", int'(pressed), 0);
      if (n >= MINT && n < LONG && j == SHORT_J) push(1, cyc + 1);
    end
  endtask

  // Scoreboard: every pulse pops an expectation; overdue expectations are misses.
  always @(negedge clock) begin
    if (!reset) begin
      if (exp_q.size() > 0 && exp_q[0].edge_n < cyc) begin
        mon_e = exp_q.pop_front();
        chk("missed_evt_cycle", cyc, mon_e.edge_n);
      end
      if (short_evt || long_evt || double_evt) begin
        mon_code = double_evt ? 3 : (long_evt ? 2 : 1);
        chk("evt_one_hot", int'(short_evt) + int'(long_evt) + int'(double_evt), 1);
        if (exp_q.size() == 0) begin
          chk("spurious_evt", mon_code, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("evt_kind", mon_code, mon_e.kind);
          chk("evt_cycle", cyc, mon_e.edge_n);
          chk("evt_count_at_evt", int'(evt_count), mon_e.cnt);
        end
      end
    end
  end

  initial begin
    #1;
    chk("rst_pressed", int'(pressed), 0);
    chk("rst_short", int'(short_evt), 0);
    chk("rst_long", int'(long_evt), 0);
    chk("rst_double", int'(double_evt), 0);
    chk("rst_hold", int'(hold_cnt), 0);
    chk("rst_count", int'(evt_count), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Runt
    press(1, 6);
    chk("runt_hold", int'(hold_cnt), 1);
    chk("runt_count", int'(evt_count), 0);

    // Short
    press(5, 6);
    chk("short_hold", int'(hold_cnt), 5);
    chk("short_count", int'(evt_count), exp_cnt);

    // Long, no event on release
    press(20, 6);
    chk("long_hold", int'(hold_cnt), 20);
    chk("long_count", int'(evt_count), exp_cnt);

    // High 3, low 2, high 3
`ifdef PRESS_CLASSIFIER_DOUBLE_CLICK_EN
    for (int i = 0; i < 3; i++) drive(1'b1);
    drive(1'b0);
    drive(1'b0);
    drive(1'b1);
    push(3, cyc + 1);
    drive(1'b1);
    drive(1'b1);
    for (int j = 0; j < 6; j++) drive(1'b0);
    chk("double_hold", int'(hold_cnt), 3);
`else
    press(3, 2);
    press(3, 6);
    chk("two_short_hold", int'(hold_cnt), 3);
`endif
    chk("double_count", int'(evt_count), exp_cnt);

    // High 3, low 6: short after release (delayed with double-click support)
    press(3, 6);
    chk("short3_count", int'(evt_count), exp_cnt);

    // clear_count on the same edge as the long event
    for (int i = 1; i < LONG; i++) drive(1'b1);
    @(negedge clock);
    sig_in = 1'b1;
    clear_count = 1'b1;
    exp_q.push_back('{2, cyc + 1, 0});
    exp_cnt = 0;
    drive(1'b1);
    clear_count = 1'b0;
    drive(1'b1);
    for (int j = 0; j < 6; j++) drive(1'b0);
    chk("clear_wins_count", int'(evt_count), 0);

    // Reset at sample 5 of a press, sig_in stays high afterwards
    for (int i = 0; i < 4; i++) drive(1'b1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("midrst_pressed", int'(pressed), 0);
    chk("midrst_hold", int'(hold_cnt), 0);
    chk("midrst_count", int'(evt_count), 0);
    chk("midrst_pulses", int'(short_evt) + int'(long_evt) + int'(double_evt), 0);
    exp_cnt = 0;
    @(negedge clock);
    reset = 1'b0;  // next rising edge samples the first 1 of a new press
    for (int i = 2; i <= 10; i++) begin
      drive(1'b1);
      if (i == LONG) push(2, cyc + 1);
    end
    for (int j = 0; j < 6; j++) drive(1'b0);
    chk("postrst_hold", int'(hold_cnt), 10);
    chk("postrst_count", int'(evt_count), 1);

    // Wrap: clear, then 256 short presses
    @(negedge clock);
    clear_count = 1'b1;
    exp_cnt = 0;
    @(negedge clock);
    clear_count = 1'b0;
    for (int k = 0; k < 256; k++) press(2, 6);
    chk("wrap_count", int'(evt_count), 0);

    repeat (10) @(negedge clock);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
